// File: rtl/y86_fetch_unit.sv
// Y86-64 sequential fetch stage: byte-serial instruction fetch, field decode and valP.
// Define FETCH_PERF_CNT_EN to add the inst_count / stall_count performance counters.
//
// state  | meaning
// FETCH  | requesting byte idx of the instruction at pc
// DONE   | decoded instruction presented, waiting for pc_load
// HALTED | halt accepted, idle until reset
// ERROR  | address or instruction error presented, idle until reset
module y86_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [7:0]  imem_rdata,
   input  logic        imem_err,
   output logic        out_valid,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [63:0] pc,
   output logic [1:0]  stat,
   input  logic        pc_load,
   input  logic [63:0] next_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] inst_count,
   output logic [31:0] stall_count
`endif
);

   typedef enum logic [1:0] {FETCH, DONE, HALTED, ERROR} state_t;

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   state_t     state;
   logic [3:0] idx;
   logic [3:0] len;
   logic [3:0] byte_len;
   logic [3:0] valc_off;
   logic [2:0] valc_byte;

   // Zero length marks an invalid icode.
   function automatic logic [3:0] inst_len(input logic [3:0] code);
      case (code)
         4'h0, 4'h1, 4'h9:             inst_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB:       inst_len = 4'd2;
         4'h3, 4'h4, 4'h5:             inst_len = 4'd10;
         4'h7, 4'h8:                   inst_len = 4'd9;
         default:                      inst_len = 4'd0;
      endcase
   endfunction

   assign byte_len  = inst_len(imem_rdata[7:4]);
   assign valc_off  = (len == 4'd10) ? (idx - 4'd2) : (idx - 4'd1);
   assign valc_byte = valc_off[2:0];

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc + {60'd0, idx};
   assign out_valid = (state == DONE) || (state == ERROR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         pc    <= RESET_PC;
         idx   <= 4'd0;
         len   <= 4'd0;
         icode <= 4'd0;
         ifun  <= 4'd0;
         rA    <= 4'hF;
         rB    <= 4'hF;
         valC  <= 64'd0;
         valP  <= RESET_PC;
         stat  <= STAT_AOK;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  if (imem_err) begin
                     state <= ERROR;
                     stat  <= STAT_ADR;
                  end else if (idx == 4'd0) begin
                     icode <= imem_rdata[7:4];
                     ifun  <= imem_rdata[3:0];
                     len   <= byte_len;
                     if (byte_len == 4'd0) begin
                        state <= ERROR;
                        stat  <= STAT_INS;
                     end else if (byte_len == 4'd1) begin
                        state <= DONE;
                        valP  <= pc + 64'd1;
                        stat  <= (imem_rdata[7:4] == 4'h0) ? STAT_HLT : STAT_AOK;
                     end else begin
                        idx <= 4'd1;
                     end
                  end else begin
                     if (idx == 4'd1 && (len == 4'd2 || len == 4'd10)) begin
                        rA <= imem_rdata[7:4];
                        rB <= imem_rdata[3:0];
                     end else if (len == 4'd9 || len == 4'd10) begin
                        valC[{valc_byte, 3'b000} +: 8] <= imem_rdata;
                     end
                     // Multi-byte instructions are never halt, so status is always AOK here.
                     if (idx == len - 4'd1) begin
                        state <= DONE;
                        valP  <= pc + {60'd0, len};
                        stat  <= STAT_AOK;
                     end else begin
                        idx <= idx + 4'd1;
                     end
                  end
               end
            end
            DONE: begin
               if (pc_load) begin
                  if (icode == 4'h0) begin
                     state <= HALTED;
                  end else begin
                     state <= FETCH;
                     pc    <= next_pc;
                     idx   <= 4'd0;
                     rA    <= 4'hF;
                     rB    <= 4'hF;
                     valC  <= 64'd0;
                  end
               end
            end
            HALTED: state <= HALTED;
            ERROR:  state <= ERROR;
            default: state <= ERROR;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_count  <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         if (state == DONE && pc_load)
            inst_count <= inst_count + 32'd1;
         if (state == FETCH && !imem_ack && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Testbench for y86_fetch_unit: directed scenarios plus randomized instructions
// checked against an instruction-level reference model.
module tb_y86_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [7:0]  imem_rdata = 8'h00;
   logic        imem_err = 1'b0;
   logic        out_valid;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP, pc;
   logic [1:0]  stat;
   logic        pc_load;
   logic [63:0] next_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] inst_count, stall_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:1023];
   int          wcnt = 0, wcfg = 0;
   bit          wait_rand = 0, err_en = 0, was_wait = 0;
   logic [63:0] err_addr = 64'd0, wait_addr = 64'd0;
   int          addr_glitch = 0;
   logic [63:0] addr_log [$];

   y86_fetch_unit #(.RESET_PC(64'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .imem_err(imem_err),
      .out_valid(out_valid), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .pc(pc), .stat(stat),
      .pc_load(pc_load), .next_pc(next_pc)
`ifdef FETCH_PERF_CNT_EN
      , .inst_count(inst_count), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   // Memory responder: decides ack for the coming rising edge on each falling edge.
   always @(negedge clk) begin
      if (imem_req) begin
         if (was_wait && imem_addr !== wait_addr) addr_glitch++;
         if (wcnt >= wcfg) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr[9:0]];
            imem_err   = err_en && (imem_addr == err_addr);
            addr_log.push_back(imem_addr);
            wcnt       = 0;
            was_wait   = 0;
            if (wait_rand) wcfg = $urandom_range(0, 2);
         end else begin
            imem_ack  = 1'b0;
            imem_err  = 1'b0;
            wcnt++;
            was_wait  = 1;
            wait_addr = imem_addr;
         end
      end else begin
         imem_ack = 1'b0;
         imem_err = 1'b0;
         wcnt     = 0;
         was_wait = 0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 300) begin
         @(posedge clk); #1;
         cycles++;
      end
      chk("valid_timeout", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic do_load(input logic [63:0] v);
      pc_load = 1'b1;
      next_pc = v;
      @(posedge clk); #1;
      pc_load = 1'b0;
   endtask

   // Reference model: decode the instruction stored at address a straight from the byte image.
   task automatic model(input logic [63:0] a, output logic [3:0] e_icode, output logic [3:0] e_ifun,
                        output logic [3:0] e_ra, output logic [3:0] e_rb, output logic [63:0] e_valc,
                        output logic [63:0] e_valp);
      int lens [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
      logic [7:0]  b [10];
      logic [63:0] t;
      int n;
      for (int k = 0; k < 10; k++) begin
         t = a + 64'(k);
         b[k] = mem[t[9:0]];
      end
      e_icode = b[0][7:4];
      e_ifun  = b[0][3:0];
      n       = lens[e_icode];
      e_ra    = (n == 2 || n == 10) ? b[1][7:4] : 4'hF;
      e_rb    = (n == 2 || n == 10) ? b[1][3:0] : 4'hF;
      e_valc  = 64'd0;
      for (int k = 0; k < 8; k++) begin
         if (n == 10) e_valc = e_valc | (64'(b[k + 2]) << (8 * k));
         if (n == 9)  e_valc = e_valc | (64'(b[k + 1]) << (8 * k));
      end
      e_valp = a + 64'(n);
   endtask

   task automatic put(input logic [63:0] a, input logic [7:0] v);
      mem[a[9:0]] = v;
   endtask

   task automatic check_model(input string tag, input logic [63:0] a);
      logic [3:0]  e_ic, e_if, e_ra, e_rb;
      logic [63:0] e_vc, e_vp;
      model(a, e_ic, e_if, e_ra, e_rb, e_vc, e_vp);
      chk({tag, "_icode"}, {60'd0, icode}, {60'd0, e_ic});
      chk({tag, "_ifun"},  {60'd0, ifun},  {60'd0, e_if});
      chk({tag, "_rA"},    {60'd0, rA},    {60'd0, e_ra});
      chk({tag, "_rB"},    {60'd0, rB},    {60'd0, e_rb});
      chk({tag, "_valC"},  valC, e_vc);
      chk({tag, "_valP"},  valP, e_vp);
      chk({tag, "_pc"},    pc, a);
      chk({tag, "_stat"},  {62'd0, stat}, 64'd0);
   endtask

   initial begin
      int cyc;
      logic [63:0] a;
      logic [7:0]  irm [10] = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
      int lens [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};

      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      rst_n = 1'b0; pc_load = 1'b0; next_pc = 64'd0;
      mem[0] = 8'h10;
      mem[1] = 8'h10;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_pc", pc, 64'd0);
      chk("rst_valP", valP, 64'd0);
      chk("rst_rArB", {56'd0, rA, rB}, 64'hFF);
      chk("rst_icode_valC", {icode, ifun, valC[55:0]}, 64'd0);
      chk("rst_stat", {62'd0, stat}, 64'd0);

      // nop at 0, zero wait
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_valid(cyc);
      chk("nop_latency", 64'(cyc), 64'd1);
      check_model("nop", 64'd0);
      chk("nop_valP", valP, 64'd1);

      do_load(64'd1);
      chk("restart_addr", imem_addr, 64'd1);
      chk("restart_valid", {63'd0, out_valid}, 64'd0);
      wait_valid(cyc);
      check_model("nop2", 64'd1);

      // irmovq at 0x100, zero wait
      for (int k = 0; k < 10; k++) put(64'h100 + 64'(k), irm[k]);
      addr_log.delete();
      do_load(64'h100);
      wait_valid(cyc);
      chk("irmovq_latency", 64'(cyc), 64'd10);
      chk("irmovq_nreq", 64'(addr_log.size()), 64'd10);
      for (int k = 0; k < 10 && k < addr_log.size(); k++)
         chk("irmovq_addr", addr_log[k], 64'h100 + 64'(k));
      chk("irmovq_valC", valC, 64'h0123456789ABCDEF);
      chk("irmovq_rArB", {56'd0, rA, rB}, 64'hF3);
      chk("irmovq_valP", valP, 64'h10A);

      // call 0x200 at 0x300, two wait cycles per byte
      put(64'h300, 8'h80);
      put(64'h301, 8'h00);
      put(64'h302, 8'h02);
      for (int k = 3; k < 9; k++) put(64'h300 + 64'(k), 8'h00);
      wcfg = 2;
      addr_glitch = 0;
      do_load(64'h300);
      wait_valid(cyc);
      chk("call_latency", 64'(cyc), 64'd27);
      chk("call_valC", valC, 64'h200);
      chk("call_valP", valP, 64'h309);
      chk("call_addr_stable", 64'(addr_glitch), 64'd0);
      check_model("call", 64'h300);
      wcfg = 0;

      // irmovq straddling the top of the address space
      a = 64'hFFFF_FFFF_FFFF_FFFE;
      for (int k = 0; k < 10; k++) put(a + 64'(k), irm[k]);
      do_load(a);
      wait_valid(cyc);
      chk("wrap_valP", valP, 64'd8);
      check_model("wrap", a);

      // randomized instructions at random 64-bit PCs with random wait states
      wait_rand = 1;
      for (int n = 0; n < 40; n++) begin
         logic [3:0] ic;
         ic = 4'($urandom_range(1, 11));
         a  = {$urandom, $urandom};
         put(a, {ic, 4'($urandom)});
         for (int k = 1; k < lens[ic]; k++) put(a + 64'(k), 8'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         do_load(a);
         wait_valid(cyc);
         check_model("rand", a);
      end
      chk("rand_addr_stable", 64'(addr_glitch), 64'd0);
      wait_rand = 0;
      @(posedge clk); #1;
      wcfg = 0;

      // invalid icode
      put(64'h200, 8'hC0);
      do_load(64'h200);
      wait_valid(cyc);
      chk("ins_stat", {62'd0, stat}, 64'd3);
      chk("ins_req", {63'd0, imem_req}, 64'd0);
      do_load(64'h50);
      repeat (3) @(posedge clk);
      #1;
      chk("ins_pc_held", pc, 64'h200);
      chk("ins_still_valid", {61'd0, out_valid, stat}, 64'h7);
      chk("ins_req_after", {63'd0, imem_req}, 64'd0);

      // reset out of ERROR, then address error on byte 3 of rmmovq
      rst_n = 1'b0;
      #1;
      chk("rst2_pc", pc, 64'd0);
      chk("rst2_valid", {63'd0, out_valid}, 64'd0);
      put(64'd0, 8'h40);
      for (int k = 1; k < 10; k++) put(64'(k), 8'h11);
      err_en = 1; err_addr = 64'd3;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_valid(cyc);
      chk("adr_stat", {62'd0, stat}, 64'd2);
      chk("adr_req", {63'd0, imem_req}, 64'd0);
      do_load(64'h40);
      chk("adr_pc_held", pc, 64'd0);
      rst_n = 1'b0;
      #1;
      chk("rst3_valid", {63'd0, out_valid}, 64'd0);
      chk("rst3_stat", {62'd0, stat}, 64'd0);
      err_en = 0;
      put(64'd0, 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // halt
      wait_valid(cyc);
      chk("hlt_latency", 64'(cyc), 64'd1);
      chk("hlt_stat", {62'd0, stat}, 64'd1);
      chk("hlt_valP", valP, 64'd1);
      do_load(64'h123);
      for (int k = 0; k < 20; k++) begin
         chk("halted_idle", {62'd0, out_valid, imem_req}, 64'd0);
         @(posedge clk); #1;
      end
`ifdef FETCH_PERF_CNT_EN
      chk("inst_count", {32'd0, inst_count}, 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
